uart_tx_monitor: RTL and testbench



---
 rtl/uart_tx_monitor.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_uart_tx_monitor.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_monitor.sv
// uart_tx_monitor: recovers 8N1 (or 8E1) frames from the SoC console line and queues the bytes.
// Latency: byte_vld_o rises CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after rxs first goes low (+CLKS_PER_BIT with parity).
// Backpressure: byte_rdy_i pops a FWFT FIFO; a good byte arriving at a full FIFO with no pop is dropped and overflow_o sticks.
//
// Optional feature macro: UART_MON_PARITY_EN (adds an even-parity bit after data bit 7).
//
// Ports:
//   clk          single system clock
//   rst          synchronous active-high reset
//   rxd          asynchronous serial input, idle high
//   byte_o       FIFO head byte (qualified by byte_vld_o)
//   byte_vld_o   FIFO non-empty
//   byte_rdy_i   consumer takes the head byte this cycle
//   frame_err_o  one-cycle pulse: bad stop bit or parity mismatch
//   overflow_o   sticky: a good byte was dropped on a full FIFO
//   fifo_cnt_o   current FIFO occupancy

// uart_mon_fifo: generic first-word-fall-through FIFO with extra-MSB pointers.
// Latency: written word visible on rd_dat_o the cycle after the write into an empty FIFO.
// Backpressure: a write when full is accepted only if a read happens in the same cycle.
module uart_mon_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_vld_i,
   input  logic [WIDTH-1:0]       wr_dat_i,
   input  logic                   rd_i,
   output logic [WIDTH-1:0]       rd_dat_o,
   output logic                   empty_o,
   output logic                   full_o,
   output logic [$clog2(DEPTH):0] cnt_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             wr_en, rd_en;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty_o  = (wr_ptr_q == rd_ptr_q);
   assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign cnt_o    = wr_ptr_q - rd_ptr_q;
   assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];

   assign rd_en = rd_i && !empty_o;
   // At full, the slot being written is the one being read out this cycle.
   assign wr_en = wr_vld_i && (!full_o || rd_en);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         // Cleared so the head output reads 0 out of reset.
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
      end
   end
endmodule

module uart_tx_monitor #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rxd,
   output logic [7:0]                  byte_o,
   output logic                        byte_vld_o,
   input  logic                        byte_rdy_i,
   output logic                        frame_err_o,
   output logic                        overflow_o,
   output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_MON_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   // ---------------------------------------------------------------
   // Input synchronizer and start-edge qualification
   // ---------------------------------------------------------------
   logic       sync1_q;
   logic       rxs_q;
   logic       rxs_d_q;
   logic [1:0] settle_q;
   logic       armed_q;
   logic       start_edge;

   // The synchronizer resets to 1, so a line held low across reset would
   // look like a 1->0 edge once real data flows through. settle_q waits
   // until rxs reflects post-reset rxd, and armed_q then requires one real
   // high sample before any falling edge is trusted.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 1'b1;
         rxs_q    <= 1'b1;
         rxs_d_q  <= 1'b1;
         settle_q <= 2'd0;
         armed_q  <= 1'b0;
      end else begin
         sync1_q  <= rxd;
         rxs_q    <= sync1_q;
         rxs_d_q  <= rxs_q;
         if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
         if (settle_q == 2'd2 && rxs_q) armed_q <= 1'b1;
      end
   end

   assign start_edge = armed_q && rxs_d_q && !rxs_q;

   // ---------------------------------------------------------------
   // Receive FSM: state register
   // ---------------------------------------------------------------
   state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [7:0] shreg_q, shreg_d;
   logic       frame_err_q;
   logic       overflow_q;
   logic       tick;
   logic       push_req;
   logic       bad_frame;
   logic       par_ok;

`ifdef UART_MON_PARITY_EN
   logic       par_q, par_d;
   // Even parity: data bits plus the received parity bit must XOR to 0.
   assign par_ok = ~(^{shreg_q, par_q});
`else
   assign par_ok = 1'b1;
`endif

   assign tick = (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         frame_err_q <= 1'b0;
`ifdef UART_MON_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         frame_err_q <= bad_frame;
`ifdef UART_MON_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

   // ---------------------------------------------------------------
   // Receive FSM: next state
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_edge) state_d = S_START;
         // A start bit that is high again at mid-bit is a glitch.
         S_START: if (tick) state_d = rxs_q ? S_IDLE : S_DATA;
         S_DATA: begin
            if (tick && bit_idx_q == 3'd7) begin
`ifdef UART_MON_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_STOP;
`endif
            end
         end
`ifdef UART_MON_PARITY_EN
         S_PARITY: if (tick) state_d = S_STOP;
`endif
         S_STOP:  if (tick) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Receive FSM: outputs and datapath updates
   // ---------------------------------------------------------------
   always_comb begin
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      push_req  = 1'b0;
      bad_frame = 1'b0;
`ifdef UART_MON_PARITY_EN
      par_d     = par_q;
`endif
      // Counter free-runs down to zero in every non-idle state; each
      // expiry is one mid-bit sample point.
      if (state_q != S_IDLE && !tick) cnt_d = cnt_q - 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start_edge) cnt_d = HALF_RELOAD;
         end
         S_START: begin
            if (tick && !rxs_q) begin
               cnt_d     = FULL_RELOAD;
               bit_idx_d = 3'd0;
            end
         end
         S_DATA: begin
            if (tick) begin
               shreg_d   = {rxs_q, shreg_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               cnt_d     = FULL_RELOAD;
            end
         end
`ifdef UART_MON_PARITY_EN
         S_PARITY: begin
            if (tick) begin
               par_d = rxs_q;
               cnt_d = FULL_RELOAD;
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               if (rxs_q && par_ok) push_req  = 1'b1;
               else                 bad_frame = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------
   // Byte FIFO and status
   // ---------------------------------------------------------------
   logic fifo_empty, fifo_full, pop;

   assign pop = byte_vld_o && byte_rdy_i;

   uart_mon_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_vld_i (push_req),
      .wr_dat_i (shreg_q),
      .rd_i     (pop),
      .rd_dat_o (byte_o),
      .empty_o  (fifo_empty),
      .full_o   (fifo_full),
      .cnt_o    (fifo_cnt_o)
   );

   // A same-cycle pop makes room, so only an unserved full FIFO drops.
   always_ff @(posedge clk) begin
      if (rst)                                  overflow_q <= 1'b0;
      else if (push_req && fifo_full && !pop)   overflow_q <= 1'b1;
   end

   assign byte_vld_o  = !fifo_empty;
   assign frame_err_o = frame_err_q;
   assign overflow_o  = overflow_q;
endmodule

// File: tb/tb_uart_tx_monitor.sv
// tb_uart_tx_monitor: directed frames at CLKS_PER_BIT=16, FIFO_DEPTH=4 with hand-computed expectations.
// Latency: expected byte/error timing derived from the rxd falling edge.
// Backpressure: byte_rdy_i driven per scenario to exercise fill, overflow and push-with-pop.
module tb_uart_tx_monitor;
   localparam int CPB   = 16;
   localparam int DEPTH = 4;
`ifdef UART_MON_PARITY_EN
   localparam int NB = 10;
`else
   localparam int NB = 9;
`endif
   // Cycles from driving the rxd falling edge to the stop-sample cycle,
   // and to the first cycle byte_vld_o / frame_err_o is visible.
   localparam int STOP_OFS = 2 + CPB / 2 + NB * CPB;
   localparam int LAT      = STOP_OFS + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd;
   logic [7:0] byte_o;
   logic       byte_vld_o;
   logic       byte_rdy_i;
   logic       frame_err_o;
   logic       overflow_o;
   logic [2:0] fifo_cnt_o;

   uart_tx_monitor #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rxd         (rxd),
      .byte_o      (byte_o),
      .byte_vld_o  (byte_vld_o),
      .byte_rdy_i  (byte_rdy_i),
      .frame_err_o (frame_err_o),
      .overflow_o  (overflow_o),
      .fifo_cnt_o  (fifo_cnt_o)
   );

   always #5 clk = ~clk;

   int         cyc = 0;
   int         n_chk = 0;
   int         n_pass = 0;
   int         vld_cnt = 0;
   int         err_cnt = 0;
   int         err_cyc = 0;
   int         frame_c0 = 0;
   logic [7:0] rx_q[$];
   int         rx_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Observe at the falling edge: record every accepted byte and error pulse.
   always @(negedge clk) begin
      if (!rst) begin
         if (byte_vld_o) vld_cnt <= vld_cnt + 1;
         if (byte_vld_o && byte_rdy_i) begin
            rx_q.push_back(byte_o);
            rx_cyc.push_back(cyc);
         end
         if (frame_err_o) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else             n_pass++;
   endtask

   function automatic logic [31:0] rx_at(int i);
      if (i < rx_q.size()) return 32'(rx_q[i]);
      return 32'hDEAD;
   endfunction

   function automatic logic [31:0] rx_lat(int i);
      if (i < rx_cyc.size()) return 32'(rx_cyc[i] - frame_c0);
      return 32'hDEAD;
   endfunction

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bit_time(input logic v);
      rxd = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
      frame_c0 = cyc;
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_MON_PARITY_EN
      bit_time((^b) ^ par_flip);
`else
      if (par_flip) rxd = 1'b1;
`endif
      bit_time(stop);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   int e0, v0;

   initial begin
      rst = 1'b1;
      rxd = 1'b1;
      byte_rdy_i = 1'b0;
      @(posedge clk);
      #1;
      do_reset();
      check("rst_vld",  byte_vld_o,  0);
      check("rst_byte", byte_o,      0);
      check("rst_err",  frame_err_o, 0);
      check("rst_ovf",  overflow_o,  0);
      check("rst_cnt",  fifo_cnt_o,  0);
      idle(10);

      // 1: single 0x55 with the consumer always ready.
      byte_rdy_i = 1'b1;
      rx_q.delete(); rx_cyc.delete();
      v0 = vld_cnt; e0 = err_cnt;
      send_frame(8'h55, 1'b1, 1'b0);
      idle(20);
      check("t1_nbytes", rx_q.size(), 1);
      check("t1_byte",   rx_at(0), 32'h55);
      check("t1_lat",    rx_lat(0), LAT);
      check("t1_vldlen", vld_cnt - v0, 1);
      check("t1_noerr",  err_cnt - e0, 0);

      // 2: ~0.3-bit glitch on an idle line.
      rx_q.delete(); rx_cyc.delete();
      e0 = err_cnt;
      rxd = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      idle(60);
      check("t2_nbytes", rx_q.size(), 0);
      check("t2_noerr",  err_cnt - e0, 0);
      check("t2_cnt",    fifo_cnt_o, 0);

      // 3: 0xA3 with a low stop bit, then a good 0x0D.
      e0 = err_cnt;
      send_frame(8'hA3, 1'b0, 1'b0);
      idle(20);
      check("t3_err1",   err_cnt - e0, 1);
      check("t3_errlat", err_cyc - frame_c0, LAT);
      check("t3_cnt",    fifo_cnt_o, 0);
      check("t3_nbytes", rx_q.size(), 0);
      send_frame(8'h0D, 1'b1, 1'b0);
      idle(20);
      check("t3_good",   rx_at(0), 32'h0D);
      check("t3_nerr",   err_cnt - e0, 1);

      // 4: six back-to-back frames into a stalled consumer.
      byte_rdy_i = 1'b0;
      rx_q.delete(); rx_cyc.delete();
      for (int i = 0; i < 6; i++) begin
         send_frame(8'(8'h41 + i), 1'b1, 1'b0);
         if (i == 3) begin
            check("t4_full_cnt", fifo_cnt_o, 4);
            check("t4_ovf_pre",  overflow_o, 0);
         end
         if (i == 4) check("t4_ovf_5th", overflow_o, 1);
      end
      idle(10);
      check("t4_cnt",  fifo_cnt_o, 4);
      check("t4_ovf",  overflow_o, 1);
      check("t4_head", byte_o, 32'h41);
      byte_rdy_i = 1'b1;
      idle(10);
      byte_rdy_i = 1'b0;
      check("t4_ndrain", rx_q.size(), 4);
      for (int i = 0; i < 4; i++) check("t4_drain", rx_at(i), 32'h41 + i);
      check("t4_empty", byte_vld_o, 0);

      // 6: reset in the middle of 0x99 with rxd held low.
      send_frame(8'h5A, 1'b1, 1'b0);
      idle(10);
      check("t6_pre_cnt", fifo_cnt_o, 1);
      check("t6_pre_ovf", overflow_o, 1);
      e0 = err_cnt;
      bit_time(1'b0);
      bit_time(1'b1);
      rxd = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("t6_vld",  byte_vld_o,  0);
      check("t6_byte", byte_o,      0);
      check("t6_err",  frame_err_o, 0);
      check("t6_ovf",  overflow_o,  0);
      check("t6_cnt",  fifo_cnt_o,  0);
      repeat (200) @(posedge clk);
      #1;
      check("t6_low_cnt", fifo_cnt_o, 0);
      check("t6_low_err", err_cnt - e0, 0);
      idle(20);
      send_frame(8'h3C, 1'b1, 1'b0);
      idle(10);
      check("t6_after_cnt",  fifo_cnt_o, 1);
      check("t6_after_byte", byte_o, 32'h3C);
`ifdef UART_MON_PARITY_EN
      e0 = err_cnt;
      send_frame(8'h07, 1'b1, 1'b1);
      idle(20);
      check("t6_par_err", err_cnt - e0, 1);
      check("t6_par_cnt", fifo_cnt_o, 1);
`endif

      // 5: full FIFO popped in the very cycle 0x7E's stop bit is sampled.
      do_reset();
      idle(10);
      byte_rdy_i = 1'b0;
      for (int i = 0; i < 4; i++) send_frame(8'(8'h41 + i), 1'b1, 1'b0);
      idle(5);
      check("t5_full", fifo_cnt_o, 4);
      rx_q.delete(); rx_cyc.delete();
      fork
         send_frame(8'h7E, 1'b1, 1'b0);
         begin
            repeat (STOP_OFS) @(posedge clk);
            #1;
            byte_rdy_i = 1'b1;
            @(posedge clk);
            #1;
            byte_rdy_i = 1'b0;
         end
      join
      idle(5);
      check("t5_cnt",    fifo_cnt_o, 4);
      check("t5_ovf",    overflow_o, 0);
      check("t5_popped", rx_at(0), 32'h41);
      byte_rdy_i = 1'b1;
      idle(10);
      check("t5_ndrain", rx_q.size(), 5);
      check("t5_b1",     rx_at(1), 32'h42);
      check("t5_last",   rx_at(4), 32'h7E);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
